// File: rtl/seg_scan_mux.sv
// Time-multiplexes four BCD digits with decimal points onto a shared 4-digit 7-segment display.
// Inputs are double-buffered and take effect at frame boundaries. Leading zeros are blanked and each slot starts with a dead time.
module seg_scan_mux #(
    parameter int SCAN_DIV     = 12500,
    parameter int BLANK_CYCLES = 500,
    parameter bit LZ_BLANK     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       update,
    input  logic [3:0] digit3,
    input  logic [3:0] digit2,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0,
    input  logic [3:0] dp_n,
    output logic [7:0] seg_n,
    output logic [3:0] an_n,
    output logic       frame_done
);

    localparam int            CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0]   cnt;
    logic [1:0]      sel;
    logic            enable_q;
    logic [3:0][3:0] in_digit;
    logic [3:0][3:0] pend_digit;
    logic [3:0][3:0] act_digit;
    logic [3:0]      pend_dp;
    logic [3:0]      act_dp;
    logic [3:0]      lead_zero;
    logic            last_cnt;
    logic            boundary;
    logic            load_active;
    logic [7:0]      seg_next;

    function automatic logic [6:0] dec7(input logic [3:0] bcd);
        case (bcd)
            4'd0:    dec7 = 7'b1000000;
            4'd1:    dec7 = 7'b1111001;
            4'd2:    dec7 = 7'b0100100;
            4'd3:    dec7 = 7'b0110000;
            4'd4:    dec7 = 7'b0011001;
            4'd5:    dec7 = 7'b0010010;
            4'd6:    dec7 = 7'b0000010;
            4'd7:    dec7 = 7'b1011000;
            4'd8:    dec7 = 7'b0000000;
            4'd9:    dec7 = 7'b0011000;
            default: dec7 = 7'b1111111;
        endcase
    endfunction

    assign in_digit = {digit3, digit2, digit1, digit0};

    // A digit is a leading zero when it and every digit to its left are zero.
    // The units digit is never blanked.
    assign lead_zero = {act_digit[3] == 4'd0,
                        act_digit[3:2] == 8'd0,
                        act_digit[3:1] == 12'd0,
                        1'b0};

    always_comb begin
        seg_next = {act_dp[sel],
                    (LZ_BLANK && lead_zero[sel]) ? 7'b1111111 : dec7(act_digit[sel])};
    end

    assign last_cnt    = (cnt == CNT_LAST);
    assign boundary    = enable && (sel == 2'd3) && last_cnt;
    assign load_active = boundary || (enable && !enable_q);

    // NOTE: The digit buffers are small flop banks, not RAM. They are reset so the display starts dark and blank-safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            sel        <= 2'd0;
            enable_q   <= 1'b0;
            pend_digit <= '0;
            act_digit  <= '0;
            pend_dp    <= 4'hF;
            act_dp     <= 4'hF;
            seg_n      <= 8'hFF;
            an_n       <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            enable_q <= enable;
            if (update) begin
                pend_digit <= in_digit;
                pend_dp    <= dp_n;
            end
            if (load_active) begin
                act_digit <= update ? in_digit : pend_digit;
                act_dp    <= update ? dp_n : pend_dp;
            end
            if (!enable) begin
                cnt        <= '0;
                sel        <= 2'd0;
                seg_n      <= 8'hFF;
                an_n       <= 4'hF;
                frame_done <= 1'b0;
            end else begin
                cnt <= last_cnt ? '0 : cnt + 1'b1;
                if (last_cnt) begin
                    sel <= sel + 2'd1;
                end
                // frame_done is registered with the other outputs.
                // It is high together with the last registered cycle of the digit-3 slot.
                frame_done <= boundary;
                if (cnt < CNT_BLANK) begin
                    seg_n <= 8'hFF;
                    an_n  <= 4'hF;
                end else begin
                    seg_n <= seg_next;
                    an_n  <= ~(4'b0001 << sel);
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux.
// It uses table vectors, hand-written corner sequences and a randomized run checked against a frame-position model.
module tb_seg_scan_mux;

    localparam int SD    = 8;
    localparam int BL    = 2;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       update;
    logic [3:0] d3, d2, d1, d0;
    logic [3:0] dp_n;
    logic [7:0] seg_n;
    logic [3:0] an_n;
    logic       frame_done;

    always #5 clk = ~clk;

    seg_scan_mux #(.SCAN_DIV(SD), .BLANK_CYCLES(BL), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .update(update),
        .digit3(d3), .digit2(d2), .digit1(d1), .digit0(d0), .dp_n(dp_n),
        .seg_n(seg_n), .an_n(an_n), .frame_done(frame_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the position within the frame, plus pending and shown digit sets.
    int         m_pos;
    logic [3:0] m_pend [4];
    logic [3:0] m_act  [4];
    logic [3:0] m_pdp, m_adp;
    bit         m_en_q;
    logic [7:0] m_seg;
    logic [3:0] m_an;
    logic       m_fd;

    function automatic logic [6:0] ref_pattern(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1011000;
            8: return 7'b0000000;
            9: return 7'b0011000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7:0] ref_seg(input int slot);
        bit blank = 1'b0;
        if (slot > 0) begin
            blank = 1'b1;
            for (int k = slot; k < 4; k++) if (m_act[k] != 4'd0) blank = 1'b0;
        end
        return {m_adp[slot], blank ? 7'b1111111 : ref_pattern(int'(m_act[slot]))};
    endfunction

    task automatic model_reset();
        m_pos  = 0;
        m_en_q = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_pend[k] = 4'd0;
            m_act[k]  = 4'd0;
        end
        m_pdp = 4'hF;
        m_adp = 4'hF;
        m_seg = 8'hFF;
        m_an  = 4'hF;
        m_fd  = 1'b0;
    endtask

    // One clock: predict from the inputs held across the edge, then compare 1 ns after the edge.
    task automatic tick();
        logic [3:0] ins [4];
        bit load = 1'b0;
        int slot, c;
        ins[0] = d0; ins[1] = d1; ins[2] = d2; ins[3] = d3;
        if (enable) begin
            slot = m_pos / SD;
            c    = m_pos % SD;
            if (c < BL) begin
                m_seg = 8'hFF;
                m_an  = 4'hF;
            end else begin
                m_seg = ref_seg(slot);
                m_an  = 4'hF ^ (4'h1 << slot);
            end
            m_fd  = (m_pos == FRAME - 1);
            load  = m_fd || !m_en_q;
            m_pos = (m_pos + 1) % FRAME;
        end else begin
            m_seg = 8'hFF;
            m_an  = 4'hF;
            m_fd  = 1'b0;
            m_pos = 0;
        end
        if (load) begin
            for (int k = 0; k < 4; k++) m_act[k] = update ? ins[k] : m_pend[k];
            m_adp = update ? dp_n : m_pdp;
        end
        if (update) begin
            for (int k = 0; k < 4; k++) m_pend[k] = ins[k];
            m_pdp = dp_n;
        end
        m_en_q = enable;
        @(posedge clk);
        #1;
        check($sformatf("model pos=%0d", m_pos), {19'd0, seg_n, an_n, frame_done},
              {19'd0, m_seg, m_an, m_fd});
    endtask

    task automatic set_inputs(input logic [15:0] digits, input logic [3:0] dp);
        {d3, d2, d1, d0} = digits;
        dp_n = dp;
    endtask

    task automatic pulse_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic wait_frame_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 2 * FRAME + 2 && !seen; i++) begin
            tick();
            seen = frame_done;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: frame_done not seen within %0d cycles", name, 2 * FRAME + 2);
        end
    endtask

    task automatic advance_to(input int p);
        for (int i = 0; i < 2 * FRAME && m_pos != p; i++) tick();
        checks++;
        if (m_pos != p) begin
            failures++;
            $display("FAIL advance_to: reached pos %0d expected %0d", m_pos, p);
        end
    endtask

    // Record the segment pattern shown in each digit slot over one frame.
    task automatic capture_frame(output logic [7:0] cap [4]);
        for (int k = 0; k < 4; k++) cap[k] = 8'hEE;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            for (int k = 0; k < 4; k++) if (an_n != 4'hF && !an_n[k]) cap[k] = seg_n;
        end
    endtask

    typedef struct packed {
        logic [15:0] digits;   // {digit3, digit2, digit1, digit0}
        logic [3:0]  dp;
        logic [31:0] exp;      // {slot3, slot2, slot1, slot0} seg_n
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] cap  [4];
    int         n;

    initial begin
        vecs[0] = '{16'h5857, 4'b1011, 32'h92_00_92_D8};
        vecs[1] = '{16'h0003, 4'hF,    32'hFF_FF_FF_B0};
        vecs[2] = '{16'h0010, 4'hF,    32'hFF_FF_F9_C0};
        vecs[3] = '{16'h123A, 4'hF,    32'hF9_A4_B0_FF};
        vecs[4] = '{16'h9046, 4'h0,    32'h18_40_19_02};
        vecs[5] = '{16'h0000, 4'b0111, 32'h7F_FF_FF_C0};
        vecs[6] = '{16'h0700, 4'hF,    32'hFF_D8_C0_C0};

        rst = 1'b0; enable = 1'b0; update = 1'b0;
        set_inputs(16'h0000, 4'hF);
        model_reset();
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("reset seg_n", {24'd0, seg_n}, 32'hFF);
        check("reset an_n", {28'd0, an_n}, 32'hF);
        check("reset frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        enable = 1'b1;

        // Table vectors
        for (int v = 0; v < 7; v++) begin
            set_inputs(vecs[v].digits, vecs[v].dp);
            pulse_update();
            wait_frame_done($sformatf("vec%0d wait", v));
            capture_frame(cap);
            for (int k = 0; k < 4; k++)
                check($sformatf("vec%0d slot%0d", v, k), {24'd0, cap[k]},
                      {24'd0, vecs[v].exp[8*k +: 8]});
        end

        // An update in the middle of a frame must wait for the frame boundary.
        set_inputs(16'h5857, 4'b1011);
        pulse_update();
        wait_frame_done("mid wait1");
        advance_to(SD + 3);
        set_inputs(16'h1234, 4'hF);
        pulse_update();
        for (int k = 0; k < 4; k++) cap[k] = 8'hEE;
        for (int i = 0; i < 2 * FRAME && !frame_done; i++) begin
            tick();
            for (int k = 0; k < 4; k++) if (an_n != 4'hF && !an_n[k]) cap[k] = seg_n;
        end
        check("mid old slot2", {24'd0, cap[2]}, 32'h00);
        check("mid old slot3", {24'd0, cap[3]}, 32'h92);
        capture_frame(cap);
        check("mid new slot3", {24'd0, cap[3]}, 32'hF9);
        check("mid new slot0", {24'd0, cap[0]}, 32'h99);
        n = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            n++;
            if (frame_done) break;
        end
        check("frame period", n, FRAME);

        // An update on the boundary cycle bypasses straight into the next frame.
        advance_to(FRAME - 1);
        set_inputs(16'h0003, 4'hF);
        pulse_update();
        check("bypass frame_done", {31'd0, frame_done}, 32'd1);
        capture_frame(cap);
        check("bypass slot3", {24'd0, cap[3]}, 32'hFF);
        check("bypass slot0", {24'd0, cap[0]}, 32'hB0);

        // With enable low the display is dark, pending still captures, and the scan restarts at digit 0.
        advance_to(2 * SD + 1);
        enable = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                set_inputs(16'h0010, 4'hF);
                update = 1'b1;
            end
            tick();
            update = 1'b0;
            if (frame_done) n++;
            check("disabled dark", {20'd0, seg_n, an_n}, {20'd0, 8'hFF, 4'hF});
        end
        check("disabled frame_done count", n, 0);
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            n++;
            if (n == 3) check("restart slot0 an_n", {28'd0, an_n}, 32'hE);
            if (frame_done) break;
        end
        check("reenable frame_done delay", n, FRAME);
        capture_frame(cap);
        check("reenable slot1", {24'd0, cap[1]}, 32'hF9);

        // Asserting reset in the middle of a slot darkens the outputs immediately.
        advance_to(2 * SD + 5);
        #2 rst = 1'b1;
        #1;
        check("async rst seg_n", {24'd0, seg_n}, 32'hFF);
        check("async rst an_n", {28'd0, an_n}, 32'hF);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        set_inputs(16'h9999, 4'h0);
        tick();
        tick();
        tick();
        check("post rst slot0", {20'd0, seg_n, an_n}, {20'd0, 8'hC0, 4'hE});

        // Randomized run against the model
        for (int i = 0; i < 1500; i++) begin
            d3 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            d2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            d1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            d0 = 4'($urandom_range(0, 15));
            dp_n   = 4'($urandom_range(0, 15));
            update = ($urandom_range(0, 9) == 0);
            enable = ($urandom_range(0, 29) != 0);
            tick();
        end
        update = 1'b0;
        enable = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
